// File: rtl/uart_pkg.sv
// Shared definitions for the memory-mapped UART: status bit positions,
// frame width and the TX/RX state encodings.
package uart_pkg;
    localparam int SR_TX_EMPTY = 0;
    localparam int SR_RX_FULL  = 1;
    localparam int SR_OVERRUN  = 2;
    localparam int DATA_BITS   = 8;

    typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_e;
    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_e;
endpackage

// File: rtl/uart_rx.sv
// 8N1 receiver: 2-FF synchronizer, start-bit qualification at half a bit,
// centre sampling; pulses byte_valid for one cycle on a good stop bit.
module uart_rx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 rxd,
    output logic                 byte_valid,
    output logic [DATA_BITS-1:0] byte_data
);
    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] FULL_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);

    rx_state_e            state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [2:0]           bit_q, bit_d;
    logic [DATA_BITS-1:0] shreg_q, shreg_d;
    logic                 sync1_q, sync1_d, sync2_q, sync2_d, prev_q, prev_d;

    always_comb begin
        sync1_d    = rxd;
        sync2_d    = sync1_q;
        prev_d     = sync2_q;
        state_d    = state_q;
        cnt_d      = cnt_q + 1'b1;
        bit_d      = bit_q;
        shreg_d    = shreg_q;
        byte_valid = 1'b0;
        case (state_q)
            RX_IDLE: begin
                cnt_d = '0;
                if (prev_q && !sync2_q) state_d = RX_START;
            end
            RX_START: if (cnt_q == HALF_LAST) begin
                // A line already back high at mid-start is noise, not a frame.
                cnt_d   = '0;
                bit_d   = '0;
                state_d = sync2_q ? RX_IDLE : RX_DATA;
            end
            RX_DATA: if (cnt_q == FULL_LAST) begin
                cnt_d   = '0;
                shreg_d = {sync2_q, shreg_q[DATA_BITS-1:1]};
                bit_d   = bit_q + 1'b1;
                if (bit_q == 3'(DATA_BITS - 1)) state_d = RX_STOP;
            end
            RX_STOP: if (cnt_q == FULL_LAST) begin
                cnt_d      = '0;
                state_d    = RX_IDLE;
                byte_valid = sync2_q;
            end
            default: state_d = RX_IDLE;
        endcase
    end

    assign byte_data = shreg_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= RX_IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            shreg_q <= '0;
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            prev_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shreg_q <= shreg_d;
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            prev_q  <= prev_d;
        end
    end
endmodule

// File: rtl/uart_mmio.sv
// Memory-mapped 8N1 UART: data port (CE_UART), status register (CE_SR),
// transmitter FSM and receive holding register around uart_rx.
module uart_mmio
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic        Clock,
    input  logic        Reset,
    input  logic        WR,
    input  logic        RD,
    input  logic        CE_SR,
    input  logic        CE_UART,
    input  logic [31:0] WriteData,
    input  logic        RxD,
    output logic        TxD,
    output logic [31:0] ReadData
);
    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] FULL_LAST = CNT_W'(CLKS_PER_BIT - 1);

    tx_state_e            tx_state_q, tx_state_d;
    logic [CNT_W-1:0]     tx_cnt_q, tx_cnt_d;
    logic [2:0]           tx_bit_q, tx_bit_d;
    logic [DATA_BITS-1:0] tx_shreg_q, tx_shreg_d;
    logic                 txd_q, txd_d;
    logic [DATA_BITS-1:0] rx_data_q, rx_data_d;
    logic                 rx_full_q, rx_full_d, overrun_q, overrun_d;
    logic                 tx_empty, tx_wr, data_rd, byte_valid;
    logic [DATA_BITS-1:0] byte_data;
    logic                 unused_wdata;

    assign unused_wdata = ^WriteData[31:DATA_BITS];
    assign tx_empty     = (tx_state_q == TX_IDLE);
    assign tx_wr        = CE_UART & WR & tx_empty;
    assign data_rd      = CE_UART & RD;
    assign TxD          = txd_q;

    uart_rx #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
        .clk       (Clock),
        .rst_n     (Reset),
        .rxd       (RxD),
        .byte_valid(byte_valid),
        .byte_data (byte_data)
    );

    always_comb begin
        tx_state_d = tx_state_q;
        tx_cnt_d   = tx_cnt_q + 1'b1;
        tx_bit_d   = tx_bit_q;
        tx_shreg_d = tx_shreg_q;
        txd_d      = txd_q;
        case (tx_state_q)
            TX_IDLE: begin
                tx_cnt_d = '0;
                if (tx_wr) begin
                    tx_shreg_d = WriteData[DATA_BITS-1:0];
                    tx_state_d = TX_START;
                    txd_d      = 1'b0;
                end
            end
            TX_START: if (tx_cnt_q == FULL_LAST) begin
                tx_cnt_d   = '0;
                tx_bit_d   = '0;
                tx_state_d = TX_DATA;
                txd_d      = tx_shreg_q[0];
                tx_shreg_d = tx_shreg_q >> 1;
            end
            TX_DATA: if (tx_cnt_q == FULL_LAST) begin
                tx_cnt_d = '0;
                if (tx_bit_q == 3'(DATA_BITS - 1)) begin
                    tx_state_d = TX_STOP;
                    txd_d      = 1'b1;
                end else begin
                    tx_bit_d   = tx_bit_q + 1'b1;
                    txd_d      = tx_shreg_q[0];
                    tx_shreg_d = tx_shreg_q >> 1;
                end
            end
            TX_STOP: if (tx_cnt_q == FULL_LAST) begin
                tx_cnt_d   = '0;
                tx_state_d = TX_IDLE;
            end
            default: tx_state_d = TX_IDLE;
        endcase
    end

    always_comb begin
        rx_data_d = rx_data_q;
        rx_full_d = rx_full_q;
        overrun_d = overrun_q;
        if (data_rd) begin
            rx_full_d = 1'b0;
            overrun_d = 1'b0;
        end
        // A completing byte beats a simultaneous read-clear.
        if (byte_valid) begin
            rx_data_d = byte_data;
            rx_full_d = 1'b1;
            if (rx_full_q && !data_rd) overrun_d = 1'b1;
        end
    end

    always_comb begin
        ReadData = '0;
        if (CE_SR && RD) begin
            ReadData[SR_TX_EMPTY] = tx_empty;
            ReadData[SR_RX_FULL]  = rx_full_q;
            ReadData[SR_OVERRUN]  = overrun_q;
        end else if (data_rd) begin
            ReadData[DATA_BITS-1:0] = rx_data_q;
        end
    end

    always_ff @(posedge Clock) begin
        if (!Reset) begin
            tx_state_q <= TX_IDLE;
            tx_cnt_q   <= '0;
            tx_bit_q   <= '0;
            tx_shreg_q <= '0;
            txd_q      <= 1'b1;
            rx_data_q  <= '0;
            rx_full_q  <= 1'b0;
            overrun_q  <= 1'b0;
        end else begin
            tx_state_q <= tx_state_d;
            tx_cnt_q   <= tx_cnt_d;
            tx_bit_q   <= tx_bit_d;
            tx_shreg_q <= tx_shreg_d;
            txd_q      <= txd_d;
            rx_data_q  <= rx_data_d;
            rx_full_q  <= rx_full_d;
            overrun_q  <= overrun_d;
        end
    end
endmodule

// File: tb/tb_uart_mmio.sv
// Scoreboard bench for uart_mmio: a line-level TX monitor and a bus-read
// monitor check against a frame/timing model driven by random stimulus.
module tb_uart_mmio;
    localparam int CPB   = 16;
    localparam int FRAME = 10 * CPB;

    logic        clk = 1'b0, rst_n = 1'b0, wr = 1'b0, rd = 1'b0;
    logic        ce_sr = 1'b0, ce_uart = 1'b0, loop_en = 1'b0, rxd_drv = 1'b1;
    logic [31:0] wdata = '0, rdata;
    logic        txd, rxd;

    assign rxd = loop_en ? txd : rxd_drv;
    always #10 clk = ~clk;

    uart_mmio #(.CLKS_PER_BIT(CPB)) dut (
        .Clock(clk), .Reset(rst_n), .WR(wr), .RD(rd), .CE_SR(ce_sr),
        .CE_UART(ce_uart), .WriteData(wdata), .RxD(rxd), .TxD(txd),
        .ReadData(rdata)
    );

    int          checks = 0, failures = 0, cyc_cnt = 0, free_edge = 0, rst_cnt = 0;
    logic [7:0]  tx_q[$];
    logic [31:0] sr_q[$], dr_q[$];
    logic        chk_sr = 1'b0;
    // Reference model of the software-visible receive state.
    logic [7:0]  m_data = '0;
    logic        m_full = 1'b0, m_ovr = 1'b0;

    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        failures++;
        $display("FAIL %s (t=%0t)", name, $time);
    endtask

    // The transmitter is free once a full frame has elapsed since the capturing edge.
    function automatic logic [31:0] m_status();
        return {29'b0, m_ovr, m_full, (cyc_cnt + 1 >= free_edge)};
    endfunction

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic rd_sr(input bit chk, output logic [31:0] v);
        if (chk) sr_q.push_back(m_status());
        chk_sr = chk; ce_sr = 1'b1; rd = 1'b1;
        #1 v = rdata;
        @(negedge clk);
        ce_sr = 1'b0; rd = 1'b0; chk_sr = 1'b0;
    endtask

    task automatic sr_check();
        logic [31:0] v;
        rd_sr(1'b1, v);
    endtask

    task automatic rd_data();
        dr_q.push_back({24'b0, m_data});
        ce_uart = 1'b1; rd = 1'b1;
        @(negedge clk);
        ce_uart = 1'b0; rd = 1'b0;
        m_full = 1'b0; m_ovr = 1'b0;
    endtask

    task automatic wr_byte(input logic [7:0] b);
        int e;
        e = cyc_cnt + 1;
        if (e >= free_edge) begin
            tx_q.push_back(b);
            free_edge = e + FRAME + 1;
        end
        ce_uart = 1'b1; wr = 1'b1; wdata = {24'($urandom), b};
        @(negedge clk);
        ce_uart = 1'b0; wr = 1'b0;
    endtask

    task automatic rx_set(input logic [7:0] b);
        if (m_full) m_ovr = 1'b1;
        m_full = 1'b1;
        m_data = b;
    endtask

    task automatic wait_tx_idle();
        while (cyc_cnt + 1 < free_edge) @(negedge clk);
    endtask

    task automatic send_rx(input logic [7:0] b, input logic stop_bit);
        rxd_drv = 1'b0; cyc(CPB);
        for (int i = 0; i < 8; i++) begin rxd_drv = b[i]; cyc(CPB); end
        rxd_drv = stop_bit; cyc(CPB);
        rxd_drv = 1'b1; cyc(4);
    endtask

    task automatic poll(input int idx, input string name);
        logic [31:0] v;
        for (int n = 0; n < 400; n++) begin
            rd_sr(1'b0, v);
            if (v[idx]) return;
        end
        fail_now(name);
    endtask

    // Bus-read monitor: compares every checked read against the queued expectation.
    initial forever begin
        @(negedge clk);
        #1;
        if (rd && ce_sr && chk_sr) begin
            if (sr_q.size() == 0) fail_now("status_unexpected");
            else check("status", rdata, sr_q.pop_front());
        end else if (rd && ce_uart && !ce_sr) begin
            if (dr_q.size() == 0) fail_now("data_unexpected");
            else check("data_read", rdata, dr_q.pop_front());
        end
    end

    // Line monitor: decodes each TxD frame at bit centres.
    initial begin
        logic       prev, s0, sp;
        logic [7:0] b;
        int         rc;
        prev = 1'b1;
        forever begin
            @(negedge clk);
            if (rst_n && prev && !txd) begin
                rc = rst_cnt;
                repeat (CPB / 2 - 1) @(negedge clk);
                s0 = txd;
                for (int i = 0; i < 8; i++) begin
                    repeat (CPB) @(negedge clk);
                    b[i] = txd;
                end
                repeat (CPB) @(negedge clk);
                sp = txd;
                if (rc == rst_cnt) begin
                    if (tx_q.size() == 0) fail_now("tx_unexpected_frame");
                    else begin
                        check("tx_byte", {24'b0, b}, {24'b0, tx_q.pop_front()});
                        check("tx_start_bit", {31'b0, s0}, 32'd0);
                        check("tx_stop_bit", {31'b0, sp}, 32'd1);
                    end
                end
            end
            prev = txd;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int         cap;
        logic [7:0] b, msg_bytes[$];
        string      msg;

        cyc(2);
        rst_n = 1'b1;
        check("reset_txd", {31'b0, txd}, 32'd1);
        check("idle_readdata", rdata, 32'd0);
        sr_check();
        rd_data();

        // Single frame with timing boundaries; a busy-time write must be dropped.
        wr_byte(8'h55);
        cap = cyc_cnt;
        check("txd_start_edge", {31'b0, txd}, 32'd0);
        sr_check();
        cyc(50);
        wr_byte(8'($urandom));
        while (cyc_cnt < cap + FRAME - 1) @(negedge clk);
        sr_check();
        check("txd_stop_level", {31'b0, txd}, 32'd1);
        sr_check();

        // Loopback single bytes.
        loop_en = 1'b1;
        cyc(2);
        for (int i = 0; i < 4; i++) begin
            b = (i == 0) ? 8'h41 : 8'($urandom);
            wr_byte(b);
            wait_tx_idle();
            rx_set(b);
            sr_check();
            rd_data();
            sr_check();
        end

        // Polled back-to-back string transfer.
        msg = "UART Victory!";
        for (int i = 0; i < msg.len(); i++) msg_bytes.push_back(msg[i]);
        msg_bytes.push_back(8'h00);
        foreach (msg_bytes[i]) begin
            poll(0, "poll_tx_empty_timeout");
            wr_byte(msg_bytes[i]);
            poll(1, "poll_rx_full_timeout");
            rx_set(msg_bytes[i]);
            rd_data();
        end
        wait_tx_idle();
        sr_check();

        // Direct RX: overrun, framing errors, random frames.
        loop_en = 1'b0;
        cyc(4);
        b = 8'($urandom); send_rx(b, 1'b1); rx_set(b);
        b = 8'($urandom); send_rx(b, 1'b1); rx_set(b);
        sr_check();
        rd_data();
        sr_check();
        for (int i = 0; i < 6; i++) begin
            logic sb;
            b  = 8'($urandom);
            sb = (i == 0) ? 1'b0 : 1'($urandom_range(0, 1));
            send_rx(b, sb);
            if (sb) rx_set(b);
            sr_check();
            if (m_full) rd_data();
        end

        // Short glitch on RxD must not start a frame.
        rxd_drv = 1'b0; cyc(4);
        rxd_drv = 1'b1; cyc(40);
        sr_check();

        // Reset in the middle of a TX frame with a byte held.
        b = 8'($urandom); send_rx(b, 1'b1); rx_set(b);
        wr_byte(8'($urandom));
        cyc(50);
        rst_n = 1'b0;
        rst_cnt++;
        tx_q.delete();
        free_edge = 0; m_full = 1'b0; m_ovr = 1'b0; m_data = '0;
        @(negedge clk);
        check("midframe_reset_txd", {31'b0, txd}, 32'd1);
        sr_check();
        rst_n = 1'b1;
        rd_data();
        cyc(200);
        wr_byte(8'($urandom));
        wait_tx_idle();
        cyc(20);

        check("tx_queue_drained", tx_q.size(), 32'd0);
        check("status_queue_drained", sr_q.size(), 32'd0);
        check("data_queue_drained", dr_q.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
